// File: rtl/riscv_fetch_pkg.sv
// Shared constants and the queue entry type for the RV32I prefetching fetch stage.
// Pure declarations; no logic and no timing.
package riscv_fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush; head visible combinationally, push-to-head 1 cycle.
// No internal backpressure: the caller must never push into a full FIFO without popping.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  T              push_dat_i,
  input  logic          pop_i,
  output T              head_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on their own.
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && !flush_i && count_q == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && count_q == '0));

endmodule

// File: rtl/instruction_fetch_queue.sv
// RV32I fetch stage: credit-limited IMEM requests feed an in-order prefetch queue to decode.
// Response-to-decode latency 1 cycle; decode stalls hold the queue and withdraw request credit.
module instruction_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);

  import riscv_fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] redirect_base;
  logic            credit_ok, req_fire, rsp_drop, push, pop;
  entry_t          push_dat, head;

  assign redirect_base = redirect_pc & ~XLEN'(3);
  assign credit_ok     = ({1'b0, inflight_q} + {1'b0, count}) < (CW + 1)'(DEPTH);

  assign imem_req_valid = reset_n && !redirect_valid && credit_ok;
  assign imem_req_addr  = {2'b00, fetch_pc_q[XLEN-1:2]};
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop      = (discard_q != '0) || redirect_valid;
  assign push          = imem_rsp_valid && !rsp_drop;
  assign push_dat.inst = imem_rsp_data;
  assign push_dat.pc   = rsp_pc_q;

  assign out_valid    = (count != '0) && !redirect_valid;
  assign pop          = out_valid && out_ready;
  assign out_inst     = out_valid ? head.inst : NOP;
  assign out_pc       = head.pc;
  assign out_pc_plus4 = out_pc + XLEN'(PC_STEP);

  // inflight counts every outstanding response, including those already
  // marked for discard, so a redirect turns all survivors into discards.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    discard_d  = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      discard_d  = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      if (push)     rsp_pc_d   = rsp_pc_q + XLEN'(PC_STEP);
      if (imem_rsp_valid && discard_q != '0) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count)
  );

  a_inflight_max: assert property (@(posedge clk) disable iff (!reset_n) inflight_q <= CW'(DEPTH));
  a_discard_max:  assert property (@(posedge clk) disable iff (!reset_n) discard_q <= CW'(DEPTH));
  a_count_max:    assert property (@(posedge clk) disable iff (!reset_n) count <= CW'(DEPTH));
  a_rsp_expected: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rsp_valid |-> inflight_q != '0);

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: directed scenarios, a queue-level reference model
// checked every cycle, and hand-computed literal pins on the key scenarios.
module tb_instruction_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;

  always #5 clk = ~clk;

  instruction_fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  // Model: each outstanding request remembers its own PC and whether it is doomed.
  typedef struct {
    logic [31:0] pc;
    int          due;
    bit          drop;
  } req_t;

  req_t        pend[$];
  logic [31:0] mq_inst[$];
  logic [31:0] mq_pc[$];
  logic [31:0] m_fetch_pc;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;
  int acc_cnt = 0;
  bit rr      = 1'b1;
  bit orr     = 1'b1;

  function automatic logic [31:0] memword(input logic [31:0] pc);
    logic [31:0] w;
    w = pc >> 2;
    return 32'hC0DE_0000 | {16'h0000, w[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    mq_inst.delete();
    mq_pc.delete();
    m_fetch_pc = 32'h0000_0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    model_clear();
    acc_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic cycle(input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
    bit          e_rv, e_ov, rsp, fire, popv;
    logic [31:0] rdat;
    req_t        r;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rr;
    out_ready      = orr;
    rsp  = (pend.size() > 0) && (pend[0].due <= cyc);
    rdat = rsp ? memword(pend[0].pc) : 32'hDEAD_BEEF;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdat;
    #2;
    e_rv = !redir && ((pend.size() + mq_pc.size()) < DEPTH);
    e_ov = !redir && (mq_pc.size() != 0);
    chk("req_valid", imem_req_valid, e_rv);
    if (e_rv) chk("req_addr", imem_req_addr, m_fetch_pc >> 2);
    chk("out_valid", out_valid, e_ov);
    if (e_ov) begin
      chk("out_inst", out_inst, mq_inst[0]);
      chk("out_pc", out_pc, mq_pc[0]);
      chk("out_pc_plus4", out_pc_plus4, mq_pc[0] + 32'd4);
    end
    if (imem_req_valid && imem_req_ready) acc_cnt++;
    fire = e_rv && rr;
    popv = e_ov && orr;
    if (popv) begin
      void'(mq_inst.pop_front());
      void'(mq_pc.pop_front());
    end
    if (rsp) begin
      r = pend.pop_front();
      if (!r.drop && !redir) begin
        mq_inst.push_back(rdat);
        mq_pc.push_back(r.pc);
      end
    end
    if (redir) begin
      mq_inst.delete();
      mq_pc.delete();
      foreach (pend[i]) pend[i].drop = 1'b1;
      m_fetch_pc = rpc & ~32'd3;
    end
    if (fire) begin
      pend.push_back('{m_fetch_pc, cyc + lat, 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int bad;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    out_ready      = 1'b0;

    // 1: streaming with 1-cycle memory
    do_reset();
    lat = 1; rr = 1'b1; orr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k < 4) chk("t1_req_addr", imem_req_addr, k);
      if (k >= 2) begin
        chk("t1_inst", out_inst, 32'hC0DE_0000 + k - 2);
        chk("t1_pc", out_pc, (k - 2) * 4);
        chk("t1_pc_plus4", out_pc_plus4, (k - 1) * 4);
      end
    end

    // 2: decode stalled, credit fills the queue, then drain
    do_reset();
    orr = 1'b0;
    repeat (8) cycle();
    chk("t2_accepted", acc_cnt, 4);
    chk("t2_req_stall", imem_req_valid, 0);
    chk("t2_head_valid", out_valid, 1);
    chk("t2_head_pc", out_pc, 0);
    orr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t2_drain_pc", out_pc, k * 4);
    end
    chk("t2_resumed", acc_cnt > 4, 1);

    // 3: redirect with three responses in flight on a 3-cycle memory
    do_reset();
    lat = 3;
    repeat (3) cycle();
    cycle(1'b1, 32'h0000_0100);
    chk("t3_redir_noreq", imem_req_valid, 0);
    seen = 1'b0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 0) chk("t3_addr", imem_req_addr, 32'h40);
      if (out_valid && out_pc < 32'h100) bad++;
      if (out_valid && !seen) begin
        seen = 1'b1;
        chk("t3_first_pc", out_pc, 32'h100);
        chk("t3_first_inst", out_inst, 32'hC0DE_0040);
      end
    end
    chk("t3_seen", seen, 1);
    chk("t3_stale", bad, 0);

    // 4: redirect coinciding with a response and a ready decode
    do_reset();
    lat = 1; orr = 1'b0;
    cycle();
    cycle();
    orr = 1'b1;
    cycle(1'b1, 32'h0000_0040);
    chk("t4_no_pop", out_valid, 0);
    chk("t4_no_req", imem_req_valid, 0);
    cycle();
    chk("t4_empty", out_valid, 0);
    chk("t4_req_valid", imem_req_valid, 1);
    chk("t4_addr", imem_req_addr, 32'h10);
    cycle();
    cycle();
    chk("t4_pc", out_pc, 32'h40);

    // 5: misaligned redirect target has its low bits cleared
    do_reset();
    cycle();
    cycle(1'b1, 32'h0000_0203);
    cycle();
    chk("t5_addr", imem_req_addr, 32'h80);
    cycle();
    cycle();
    chk("t5_valid", out_valid, 1);
    chk("t5_pc", out_pc, 32'h200);
    chk("t5_pc_plus4", out_pc_plus4, 32'h204);

    // PC wrap at the top of the address space
    cycle(1'b1, 32'hFFFF_FFF8);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (out_valid && out_pc == 32'hFFFF_FFFC) begin
        seen = 1'b1;
        chk("wrap_pc_plus4", out_pc_plus4, 32'h0);
      end
    end
    chk("wrap_seen", seen, 1);

    // back-to-back redirects accumulate discards
    do_reset();
    lat = 3;
    repeat (2) cycle();
    cycle(1'b1, 32'h0000_0300);
    cycle(1'b1, 32'h0000_0400);
    cycle();
    cycle(1'b1, 32'h0000_0500);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (out_valid && !seen) begin
        seen = 1'b1;
        chk("b2b_first_pc", out_pc, 32'h500);
      end
    end
    chk("b2b_seen", seen, 1);

    // 6: reset mid-stream with entries queued and in flight
    do_reset();
    lat = 2; orr = 1'b0;
    repeat (4) cycle();
    chk("t6_queued", out_valid, 1);
    do_reset();
    orr = 1'b1;
    cycle();
    chk("t6_restart_addr", imem_req_addr, 32'h0);
    repeat (6) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
